i2s_rx: RTL and testbench
=========================

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter SAMPLE_W, default 24: number of data bits captured per channel.
REQ-002 Parameter SLOT_W, default 32: SCK cycles per channel slot; SLOT_W >= SAMPLE_W+1.
REQ-003 Parameter WS_POL, default 1'b0: WS level denoting the left channel.
REQ-004 Parameter SYNC_STAGES, default 2: synchronizer depth for sck_i, ws_i and sd_i; minimum 2.
REQ-005 clk_i  input  1  system clock, 27 MHz nominal; one clock domain; the block has no other clock.
REQ-006 rst_i  input  1  reset, synchronous to clk_i, active-high.
REQ-007 sck_i  input  1  external I2S bit clock, asynchronous to clk_i.
REQ-008 ws_i  input  1  external word select.
REQ-009 sd_i  input  1  serial data, MSB first.
REQ-010 left_o  output  SAMPLE_W  left sample of the presented pair.
REQ-011 right_o  output  SAMPLE_W  right sample of the presented pair.
REQ-012 valid_o  output  1  pair presented.
REQ-013 ready_i  input  1  consumer accepts the pair.
REQ-014 overrun_o  output  1  one-cycle pulse when an unaccepted pair is overwritten.
REQ-015 frame_err_o  output  1  one-cycle pulse on a slot-length error; the port is always present.

Function
REQ-016 sck_i, ws_i and sd_i shall each pass through SYNC_STAGES flops so that all three have equal delay; f(clk_i) >= 8*f(sck_i).
REQ-017 A synchronized SCK 0->1 transition shall produce a one-cycle rise pulse; ws and sd shall be sampled only in that cycle.
REQ-018 FSM states shall be S_WAIT_LEFT, S_LEFT and S_RIGHT.
REQ-019 The first rise pulse after reset shall only load ws_prev; no transition shall be detected on that edge.
REQ-020 A WS transition is sampled ws != ws_prev at a rise pulse.
REQ-021 At a transition, the sd bit sampled on that edge belongs to the previous slot and shall be discarded.
REQ-022 At a transition, bit_ctr shall clear to 0, so that the channel MSB is the sd bit on the next rise pulse (I2S one-bit delay).
REQ-023 S_WAIT_LEFT: on a transition to WS_POL, go to S_LEFT; ignore all other edges.
REQ-024 S_LEFT/S_RIGHT: while bit_ctr < SAMPLE_W, shift sd into the shift register, MSB first, and increment bit_ctr.
REQ-025 S_LEFT/S_RIGHT: once bit_ctr >= SAMPLE_W, ignore further bits; bit_ctr shall saturate at SLOT_W and never wrap.
REQ-026 S_LEFT, transition to ~WS_POL: if bit_ctr >= SAMPLE_W, copy the shift register to left_hold and go to S_RIGHT; otherwise discard and go to S_WAIT_LEFT.
REQ-027 S_RIGHT, on the rise pulse shifting the SAMPLE_W-th bit: load left_hold and the right word into left_o/right_o; valid_o shall be high on the next clk_i cycle.
REQ-028 S_RIGHT, transition to WS_POL: go to S_LEFT; a short right slot discards the pair.
REQ-029 valid_o shall remain high with stable data until a cycle with valid_o && ready_i; valid_o shall then deassert unless a new pair loads in the same cycle.
REQ-030 New pair load while valid_o && !ready_i: the new pair shall overwrite the outputs, valid_o stays high, and overrun_o pulses for one cycle.
REQ-031 New pair load with valid_o && ready_i in the same cycle: the old pair counts as accepted, the new pair loads, and there shall be no overrun.

Reset
REQ-032 While rst_i is high, all synchronizer flops, ws_prev, bit_ctr, the shift register, left_hold and all outputs shall be 0, and the state shall be S_WAIT_LEFT.
REQ-033 Reset asserted mid-slot shall abandon the partial word; capture shall restart per REQ-019 and REQ-023.

Configuration
REQ-034 With macro I2S_RX_FRAME_CHECK_EN defined, a slot counter shall count rise pulses per slot.
REQ-035 With I2S_RX_FRAME_CHECK_EN defined, frame_err_o shall pulse for one cycle at any transition where the slot length != SLOT_W, excluding the first transition after reset.
REQ-036 With I2S_RX_FRAME_CHECK_EN undefined, frame_err_o shall be tied to 0 and no slot-counter logic shall be built.

Structure
REQ-037 Package i2s_pkg shall hold the i2s_rx_state_e enum and the default constants I2S_SAMPLE_W=24 and I2S_SLOT_W=32.
REQ-038 Sub-module i2s_edge_sync shall implement the parameterized synchronizer plus rise-pulse detector; i2s_rx shall instantiate it once for SCK.
REQ-039 ws and sd shall use plain delay stages of the same depth, so that all three signals stay aligned.

Verification (clk 27 MHz, SCK = clk/8, SLOT_W=32, SAMPLE_W=24, WS_POL=0)
REQ-040 Left 0xA5A5A5, right 0x5A5A5A, ready_i=1 -> one valid_o cycle with left_o=0xA5A5A5 and right_o=0x5A5A5A; overrun_o=0.
REQ-041 ready_i=0 across frames (0x111111/0x222222) then (0x333333/0x444444) -> overrun_o pulses once; outputs = 0x333333/0x444444; valid_o stays high.
REQ-042 rst_i pulsed at left bit 10 -> all outputs 0; the next full frame delivers a correct pair; no partial pair is ever presented.
REQ-043 Left slot of 16 SCKs -> no valid_o for that frame; frame_err_o pulses with I2S_RX_FRAME_CHECK_EN defined and stays 0 without it; the next normal frame is correct.
REQ-044 WS_POL=1, left 0x800001, right 0x7FFFFF -> left_o=0x800001, right_o=0x7FFFFF.
REQ-045 ready_i asserted in the same cycle a new pair loads, for back-to-back frames -> every pair is delivered, valid_o is continuous and overrun_o=0.

Source files
------------

// File: rtl/i2s_pkg.sv
// I2S receiver shared state encoding and default frame geometry.
package i2s_pkg;

    localparam int I2S_SAMPLE_W = 24;
    localparam int I2S_SLOT_W   = 32;

    typedef enum logic [1:0] {
        S_WAIT_LEFT = 2'd0,
        S_LEFT      = 2'd1,
        S_RIGHT     = 2'd2
    } i2s_rx_state_e;

endpackage

// File: rtl/i2s_rx_if.sv
// Sample-pair output bundle of the I2S receiver.
// master drives the pair, slave consumes it via ready_i.
interface i2s_rx_if
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = I2S_SAMPLE_W
);

    logic [SAMPLE_W-1:0] left_o;
    logic [SAMPLE_W-1:0] right_o;
    logic                valid_o;
    logic                ready_i;
    logic                overrun_o;
    logic                frame_err_o;

    modport master (
        output left_o,
        output right_o,
        output valid_o,
        output overrun_o,
        output frame_err_o,
        input  ready_i
    );

    modport slave (
        input  left_o,
        input  right_o,
        input  valid_o,
        input  overrun_o,
        input  frame_err_o,
        output ready_i
    );

endinterface

// File: rtl/i2s_edge_sync.sv
// Multi-flop synchronizer with a one-cycle rising-edge pulse.
// rise_o is aligned with the last synchronizer stage.
module i2s_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversampled SCK/WS/SD capture into a left/right pair.
// Define I2S_RX_FRAME_CHECK_EN to build the slot-length checker.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int   SAMPLE_W    = I2S_SAMPLE_W,
    parameter int   SLOT_W      = I2S_SLOT_W,
    parameter logic WS_POL      = 1'b0,
    parameter int   SYNC_STAGES = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     sck_i,
    input  logic     ws_i,
    input  logic     sd_i,
    i2s_rx_if.master pcm
);

    localparam int CTR_W = $clog2(SLOT_W + 1);
    localparam logic [CTR_W-1:0] CTR_ONE    = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_SAMPLE = CTR_W'(SAMPLE_W);
    localparam logic [CTR_W-1:0] CTR_LAST   = CTR_W'(SAMPLE_W - 1);
    localparam logic [CTR_W-1:0] CTR_SLOT   = CTR_W'(SLOT_W);

    logic                   rise;
    logic [SYNC_STAGES-1:0] ws_dly_q;
    logic [SYNC_STAGES-1:0] sd_dly_q;
    logic                   ws_s;
    logic                   sd_s;
    logic                   primed_q;
    logic                   ws_prev_q;
    logic [1:0]             state_q;
    logic [CTR_W-1:0]       bit_ctr_q;
    logic [SAMPLE_W-1:0]    shift_q;
    logic [SAMPLE_W-1:0]    left_hold_q;
    logic [SAMPLE_W-1:0]    shift_nxt;
    logic                   trans;
    logic                   capture;
    logic                   load;

    i2s_edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sck_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (sck_i),
        .rise_o (rise)
    );

    // Same depth as the SCK synchronizer so ws/sd line up with rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ws_dly_q <= '0;
            sd_dly_q <= '0;
        end else begin
            ws_dly_q <= {ws_dly_q[SYNC_STAGES-2:0], ws_i};
            sd_dly_q <= {sd_dly_q[SYNC_STAGES-2:0], sd_i};
        end
    end

    assign ws_s = ws_dly_q[SYNC_STAGES-1];
    assign sd_s = sd_dly_q[SYNC_STAGES-1];

    assign trans = rise && primed_q && (ws_s != ws_prev_q);

    assign capture = rise && !trans
                  && (state_q != S_WAIT_LEFT)
                  && (bit_ctr_q < CTR_SAMPLE);

    assign shift_nxt = {shift_q[SAMPLE_W-2:0], sd_s};

    assign load = capture
               && (state_q == S_RIGHT)
               && (bit_ctr_q == CTR_LAST);

    // The sd bit on a WS transition edge is the previous slot's tail.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            primed_q    <= 1'b0;
            ws_prev_q   <= 1'b0;
            state_q     <= S_WAIT_LEFT;
            bit_ctr_q   <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
        end else if (rise) begin
            primed_q  <= 1'b1;
            ws_prev_q <= ws_s;
            if (trans) begin
                bit_ctr_q <= '0;
                unique case (state_q)
                    S_WAIT_LEFT: begin
                        if (ws_s == WS_POL)
                            state_q <= S_LEFT;
                    end
                    S_LEFT: begin
                        if (bit_ctr_q >= CTR_SAMPLE) begin
                            left_hold_q <= shift_q;
                            state_q     <= S_RIGHT;
                        end else begin
                            state_q <= S_WAIT_LEFT;
                        end
                    end
                    S_RIGHT: state_q <= S_LEFT;
                    default: state_q <= S_WAIT_LEFT;
                endcase
            end else if (state_q != S_WAIT_LEFT) begin
                if (capture)
                    shift_q <= shift_nxt;
                if (bit_ctr_q < CTR_SLOT)
                    bit_ctr_q <= bit_ctr_q + CTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcm.left_o    <= '0;
            pcm.right_o   <= '0;
            pcm.valid_o   <= 1'b0;
            pcm.overrun_o <= 1'b0;
        end else begin
            pcm.overrun_o <= 1'b0;
            if (load) begin
                pcm.left_o    <= left_hold_q;
                pcm.right_o   <= shift_nxt;
                pcm.valid_o   <= 1'b1;
                pcm.overrun_o <= pcm.valid_o && !pcm.ready_i;
            end else if (pcm.valid_o && pcm.ready_i) begin
                pcm.valid_o <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam int SLOT_CTR_W = $clog2(SLOT_W + 2);
    localparam logic [SLOT_CTR_W-1:0] SLOT_ONE = SLOT_CTR_W'(1);
    localparam logic [SLOT_CTR_W-1:0] SLOT_LEN = SLOT_CTR_W'(SLOT_W);
    localparam logic [SLOT_CTR_W-1:0] SLOT_MAX = SLOT_CTR_W'(SLOT_W + 1);

    logic [SLOT_CTR_W-1:0] slot_ctr_q;
    logic                  seen_trans_q;
    logic                  frame_err_q;

    // The transition edge is the first SCK of the new slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_ctr_q   <= '0;
            seen_trans_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (trans) begin
                slot_ctr_q   <= SLOT_ONE;
                seen_trans_q <= 1'b1;
                frame_err_q  <= seen_trans_q
                             && (slot_ctr_q != SLOT_LEN);
            end else if (rise && (slot_ctr_q < SLOT_MAX)) begin
                slot_ctr_q <= slot_ctr_q + SLOT_ONE;
            end
        end
    end

    assign pcm.frame_err_o = frame_err_q;
`else
    assign pcm.frame_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: SCK = clk/8, 32-bit slots, 24-bit samples.
module tb_i2s_rx;
    import i2s_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic ws  = 1'b1;
    logic sd  = 1'b0;
    logic rdy = 1'b1;
    logic ws_n;

    int checks = 0;
    int failures = 0;

    i2s_rx_if #(.SAMPLE_W(24)) pcm0 ();
    i2s_rx_if #(.SAMPLE_W(24)) pcm1 ();

    assign ws_n = ~ws;
    assign pcm0.ready_i = rdy;
    assign pcm1.ready_i = 1'b1;

    always #19 clk = ~clk;

    i2s_rx #(
        .SAMPLE_W (24),
        .SLOT_W   (32),
        .WS_POL   (1'b0)
    ) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .sck_i (sck),
        .ws_i  (ws),
        .sd_i  (sd),
        .pcm   (pcm0)
    );

    i2s_rx #(
        .SAMPLE_W (24),
        .SLOT_W   (32),
        .WS_POL   (1'b1)
    ) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .sck_i (sck),
        .ws_i  (ws_n),
        .sd_i  (sd),
        .pcm   (pcm1)
    );

    int vcnt0 = 0;
    int vlow0 = 0;
    int ocnt0 = 0;
    int fcnt0 = 0;
    int vcnt1 = 0;
    logic [23:0] last_l0 = '0;
    logic [23:0] last_r0 = '0;
    logic [23:0] last_l1 = '0;
    logic [23:0] last_r1 = '0;
    logic [23:0] acc_l[$];
    logic [23:0] acc_r[$];

    // Observe just after each negedge; rdy then holds its next-posedge value.
    always @(negedge clk) begin
        #1;
        if (pcm0.valid_o) begin
            vcnt0++;
            last_l0 = pcm0.left_o;
            last_r0 = pcm0.right_o;
        end else begin
            vlow0++;
        end
        if (pcm0.overrun_o) ocnt0++;
        if (pcm0.frame_err_o) fcnt0++;
        if (pcm0.valid_o && rdy) begin
            acc_l.push_back(pcm0.left_o);
            acc_r.push_back(pcm0.right_o);
        end
        if (pcm1.valid_o) begin
            vcnt1++;
            last_l1 = pcm1.left_o;
            last_r1 = pcm1.right_o;
        end
    end

    // The rdy pulse lands on the posedge where the pair loads (sync depth 2).
    task automatic send_bit(input logic w, input logic d,
                            input logic pulse);
        @(negedge clk);
        sck = 1'b0;
        ws  = w;
        sd  = d;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (2) @(negedge clk);
        if (pulse) rdy = 1'b1;
        @(negedge clk);
        if (pulse) rdy = 1'b0;
    endtask

    task automatic send_slot(input logic w, input logic [23:0] word,
                             input int len, input logic pulse);
        for (int i = 0; i < len; i++) begin
            logic d;
            if (i == 0) d = 1'b1;
            else if (i <= 24) d = word[24-i];
            else d = 1'b0;
            send_bit(w, d, pulse && (i == 24));
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                              input int len_l, input logic pulse);
        send_slot(1'b0, l, len_l, 1'b0);
        send_slot(1'b1, r, 32, pulse);
    endtask

    task automatic idle_bits();
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pcm0.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", pcm0.valid_o);
        end
        checks++;
        if (pcm0.left_o !== 24'h0) begin
            failures++;
            $display("FAIL reset_left got=%h exp=0", pcm0.left_o);
        end
        checks++;
        if (pcm0.right_o !== 24'h0) begin
            failures++;
            $display("FAIL reset_right got=%h exp=0", pcm0.right_o);
        end
        checks++;
        if (pcm0.overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_overrun got=%b exp=0", pcm0.overrun_o);
        end
        checks++;
        if (pcm0.frame_err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ferr got=%b exp=0", pcm0.frame_err_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int v0, o0, f0;
        rdy = 1'b1;
        idle_bits();
        v0 = vcnt0; o0 = ocnt0; f0 = fcnt0;
        send_frame(24'hA5A5A5, 24'h5A5A5A, 32, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (vcnt0 - v0 !== 1) begin
            failures++;
            $display("FAIL basic_vcnt got=%0d exp=1", vcnt0 - v0);
        end
        checks++;
        if (last_l0 !== 24'hA5A5A5) begin
            failures++;
            $display("FAIL basic_left got=%h exp=a5a5a5", last_l0);
        end
        checks++;
        if (last_r0 !== 24'h5A5A5A) begin
            failures++;
            $display("FAIL basic_right got=%h exp=5a5a5a", last_r0);
        end
        checks++;
        if (ocnt0 - o0 !== 0) begin
            failures++;
            $display("FAIL basic_ovr got=%0d exp=0", ocnt0 - o0);
        end
        checks++;
        if (fcnt0 - f0 !== 0) begin
            failures++;
            $display("FAIL basic_ferr got=%0d exp=0", fcnt0 - f0);
        end
    endtask

    task automatic test_overrun();
        int o0;
        rdy = 1'b0;
        o0 = ocnt0;
        send_frame(24'h111111, 24'h222222, 32, 1'b0);
        send_frame(24'h333333, 24'h444444, 32, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (ocnt0 - o0 !== 1) begin
            failures++;
            $display("FAIL ovr_count got=%0d exp=1", ocnt0 - o0);
        end
        checks++;
        if (pcm0.left_o !== 24'h333333) begin
            failures++;
            $display("FAIL ovr_left got=%h exp=333333", pcm0.left_o);
        end
        checks++;
        if (pcm0.right_o !== 24'h444444) begin
            failures++;
            $display("FAIL ovr_right got=%h exp=444444", pcm0.right_o);
        end
        checks++;
        if (pcm0.valid_o !== 1'b1) begin
            failures++;
            $display("FAIL ovr_valid got=%b exp=1", pcm0.valid_o);
        end
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pcm0.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL ovr_drain got=%b exp=0", pcm0.valid_o);
        end
        rdy = 1'b1;
    endtask

    task automatic test_reset_mid();
        int v0, f0;
        rdy = 1'b1;
        v0 = vcnt0;
        send_slot(1'b0, 24'hFFFFFF, 11, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pcm0.valid_o !== 1'b0 || pcm0.left_o !== 24'h0
            || pcm0.right_o !== 24'h0) begin
            failures++;
            $display("FAIL rstmid_outs got=%b/%h/%h exp=0/0/0",
                     pcm0.valid_o, pcm0.left_o, pcm0.right_o);
        end
        rst = 1'b0;
        @(negedge clk);
        f0 = fcnt0;
        idle_bits();
        send_frame(24'h123456, 24'h654321, 32, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (vcnt0 - v0 !== 1) begin
            failures++;
            $display("FAIL rstmid_vcnt got=%0d exp=1", vcnt0 - v0);
        end
        checks++;
        if (last_l0 !== 24'h123456 || last_r0 !== 24'h654321) begin
            failures++;
            $display("FAIL rstmid_pair got=%h/%h exp=123456/654321",
                     last_l0, last_r0);
        end
        checks++;
        if (fcnt0 - f0 !== 0) begin
            failures++;
            $display("FAIL rstmid_ferr got=%0d exp=0", fcnt0 - f0);
        end
    endtask

    task automatic test_short_slot();
        int v0, f0, exp_f;
`ifdef I2S_RX_FRAME_CHECK_EN
        exp_f = 1;
`else
        exp_f = 0;
`endif
        rdy = 1'b1;
        v0 = vcnt0; f0 = fcnt0;
        send_frame(24'hABCDEF, 24'h13579B, 16, 1'b0);
        send_frame(24'h0F0F0F, 24'hF0F0F0, 32, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (vcnt0 - v0 !== 1) begin
            failures++;
            $display("FAIL short_vcnt got=%0d exp=1", vcnt0 - v0);
        end
        checks++;
        if (last_l0 !== 24'h0F0F0F || last_r0 !== 24'hF0F0F0) begin
            failures++;
            $display("FAIL short_pair got=%h/%h exp=0f0f0f/f0f0f0",
                     last_l0, last_r0);
        end
        checks++;
        if (fcnt0 - f0 !== exp_f) begin
            failures++;
            $display("FAIL short_ferr got=%0d exp=%0d", fcnt0 - f0, exp_f);
        end
    endtask

    task automatic test_ws_pol();
        int v1;
        rdy = 1'b1;
        v1 = vcnt1;
        send_frame(24'h800001, 24'h7FFFFF, 32, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (vcnt1 - v1 !== 1) begin
            failures++;
            $display("FAIL pol_vcnt got=%0d exp=1", vcnt1 - v1);
        end
        checks++;
        if (last_l1 !== 24'h800001) begin
            failures++;
            $display("FAIL pol_left got=%h exp=800001", last_l1);
        end
        checks++;
        if (last_r1 !== 24'h7FFFFF) begin
            failures++;
            $display("FAIL pol_right got=%h exp=7fffff", last_r1);
        end
    endtask

    task automatic test_back_to_back();
        int o0, a0, lo_a, lo_b;
        logic [23:0] exp_l [3];
        logic [23:0] exp_r [3];
        exp_l[0] = 24'hC0FFEE; exp_r[0] = 24'h000001;
        exp_l[1] = 24'hDEAD01; exp_r[1] = 24'hBEEF02;
        exp_l[2] = 24'h00F00D; exp_r[2] = 24'hFFFFFE;
        rdy = 1'b0;
        @(negedge clk);
        o0 = ocnt0;
        a0 = acc_l.size();
        send_frame(exp_l[0], exp_r[0], 32, 1'b1);
        lo_a = vlow0;
        send_frame(exp_l[1], exp_r[1], 32, 1'b1);
        send_frame(exp_l[2], exp_r[2], 32, 1'b1);
        lo_b = vlow0;
        checks++;
        if (lo_b - lo_a !== 0) begin
            failures++;
            $display("FAIL b2b_gap got=%0d exp=0", lo_b - lo_a);
        end
        checks++;
        if (ocnt0 - o0 !== 0) begin
            failures++;
            $display("FAIL b2b_ovr got=%0d exp=0", ocnt0 - o0);
        end
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (acc_l.size() - a0 !== 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", acc_l.size() - a0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (acc_l[a0+k] !== exp_l[k] || acc_r[a0+k] !== exp_r[k]) begin
                    failures++;
                    $display("FAIL b2b_pair%0d got=%h/%h exp=%h/%h", k,
                             acc_l[a0+k], acc_r[a0+k], exp_l[k], exp_r[k]);
                end
            end
        end
        rdy = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_reset_mid();
        test_short_slot();
        test_ws_pol();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
